// File: rtl/i2c_accel_slave.sv
// rtl/i2c_accel_slave.sv - I2C target emulating the accelerometer register map
module i2c_accel_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h68,
    parameter logic [7:0] WHO_AM_I    = 8'h68,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic       host_wr_en,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       bus_wr_strobe,
    output logic [6:0] bus_wr_addr,
    output logic [7:0] bus_wr_data,
    output logic       busy,
    output logic [6:0] reg_ptr
);
    localparam logic [6:0] WHO_AM_I_REG = 7'd117;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_d, sda_d;
    logic       start_ev, stop_ev, scl_rise, scl_fall;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] bit_in;
    logic       rw;
    logic       byte_done, addr_match, bus_we;
    logic [7:0] rd_data;
    logic [7:0] regs [128];

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign start_ev   = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev    = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign byte_done  = (bit_cnt == 4'd8);
    assign addr_match = (shift[7:1] == SLAVE_ADDR);
    assign bit_in     = {shift[6:0], sda_s};
    assign rd_data    = (reg_ptr == WHO_AM_I_REG) ? WHO_AM_I : regs[reg_ptr];
    assign bus_we     = (state == WDATA) && scl_rise && (bit_cnt == 4'd7) && !start_ev && !stop_ev;
    assign busy       = state inside {ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK};

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (start_ev) begin
            state_n = ADDR;
        end else if (stop_ev) begin
            state_n = IDLE;
        end else begin
            case (state)
                ADDR:      if (scl_fall && byte_done) state_n = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (scl_fall) state_n = rw ? RDATA : REG;
                REG:       if (scl_fall && byte_done) state_n = REG_ACK;
                REG_ACK:   if (scl_fall) state_n = WDATA;
                WDATA:     if (scl_fall && byte_done) state_n = WDATA_ACK;
                WDATA_ACK: if (scl_fall) state_n = WDATA;
                RDATA:     if (scl_fall && byte_done) state_n = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && sda_s) state_n = IGNORE;
                    else if (scl_fall)     state_n = RDATA;
                end
                default: ;
            endcase
        end
    end

    // Shift/ACK datapath: bits sampled on scl_s rise, SDA only moves on scl_s fall.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= 4'd0;
            shift         <= 8'h00;
            rw            <= 1'b0;
            sda_out       <= 1'b1;
            reg_ptr       <= 7'd0;
            bus_wr_strobe <= 1'b0;
            bus_wr_addr   <= 7'd0;
            bus_wr_data   <= 8'h00;
        end else begin
            bus_wr_strobe <= 1'b0;
            if (start_ev || stop_ev) begin
                bit_cnt <= 4'd0;
                sda_out <= 1'b1;
            end else begin
                case (state)
                    ADDR, REG, WDATA: begin
                        if (scl_rise && !byte_done) begin
                            shift   <= bit_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (scl_rise && bit_cnt == 4'd7) begin
                            if (state == REG) reg_ptr <= bit_in[6:0];
                            if (state == WDATA) begin
                                bus_wr_strobe <= 1'b1;
                                bus_wr_addr   <= reg_ptr;
                                bus_wr_data   <= bit_in;
                                reg_ptr       <= reg_ptr + 7'd1;
                            end
                        end
                        if (scl_fall && byte_done) begin
                            bit_cnt <= 4'd0;
                            if (state != ADDR || addr_match) sda_out <= 1'b0;
                            if (state == ADDR) rw <= shift[0];
                        end
                    end
                    ADDR_ACK, REG_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (state == ADDR_ACK && rw) begin
                                shift   <= rd_data;
                                sda_out <= rd_data[7];
                                reg_ptr <= reg_ptr + 7'd1;
                            end else begin
                                sda_out <= 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (byte_done) begin
                                sda_out <= 1'b1;
                                bit_cnt <= 4'd0;
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_out <= shift[6];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_fall) begin
                            shift   <= rd_data;
                            sda_out <= rd_data[7];
                            reg_ptr <= reg_ptr + 7'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Host port has priority over a bus write landing on the same register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 128; i++) regs[i] <= (i == 107) ? 8'h40 : 8'h00;
        end else begin
            for (int i = 0; i < 128; i++) begin
                if (host_wr_en && host_addr == 7'(i))
                    regs[i] <= host_wdata;
                else if (bus_we && reg_ptr == 7'(i) && reg_ptr != WHO_AM_I_REG)
                    regs[i] <= bit_in;
            end
        end
    end
endmodule

// File: tb/tb_i2c_accel_slave.sv
// tb/tb_i2c_accel_slave.sv - scoreboard bench for i2c_accel_slave with a register-map model
module tb_i2c_accel_slave;
    logic       clk_in = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_out;
    logic       host_wr_en = 1'b0;
    logic [6:0] host_addr = 7'd0;
    logic [7:0] host_wdata = 8'h00;
    logic       bus_wr_strobe;
    logic [6:0] bus_wr_addr;
    logic [7:0] bus_wr_data;
    logic       busy;
    logic [6:0] reg_ptr;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  model_regs [128];
    logic [6:0]  model_ptr;
    logic [14:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  obs_rd_q[$];
    logic [7:0]  tx_bytes[$];
    logic [14:0] exp_e;

    assign sda_line = sda_m & sda_out;

    i2c_accel_slave dut (
        .clk_in(clk_in), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_line),
        .sda_out(sda_out), .host_wr_en(host_wr_en), .host_addr(host_addr),
        .host_wdata(host_wdata), .bus_wr_strobe(bus_wr_strobe), .bus_wr_addr(bus_wr_addr),
        .bus_wr_data(bus_wr_data), .busy(busy), .reg_ptr(reg_ptr)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        return (a == 7'd117) ? 8'h68 : model_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) model_regs[i] = 8'h00;
        model_regs[107] = 8'h40;
        model_ptr = 7'd0;
    endtask

    always @(negedge clk_in) begin
        if (reset_n && bus_wr_strobe) begin
            if (exp_wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_strobe: got strobe addr 0x%0h data 0x%0h expected none", bus_wr_addr, bus_wr_data);
            end else begin
                exp_e = exp_wr_q.pop_front();
                check("wr_addr", 32'(bus_wr_addr), 32'(exp_e[14:8]));
                check("wr_data", 32'(bus_wr_data), 32'(exp_e[7:0]));
            end
        end
        if (obs_rd_q.size() > 0) begin
            if (exp_rd_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_data: got 0x%0h expected nothing", obs_rd_q.pop_front());
            end else begin
                check("rd_data", 32'(obs_rd_q.pop_front()), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    task automatic wait_q();
        repeat (4) @(negedge clk_in);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q(); wait_q();
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_wr_en = 1'b1;
        @(negedge clk_in);
        host_wr_en = 1'b0;
        model_regs[a] = d;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit race, input bit abort,
                              output logic ack, output logic bsy);
        bit seen;
        seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_q();
            scl_m = 1'b1;
            if (race && i == 0) begin
                host_addr = 7'd59; host_wdata = 8'h33; host_wr_en = 1'b1;
                for (int k = 0; k < 12 && !seen; k++) begin
                    @(negedge clk_in);
                    if (bus_wr_strobe) seen = 1'b1;
                end
                host_wr_en = 1'b0;
                check("race_strobe_seen", 32'(seen), 32'd1);
            end
            wait_q(); wait_q();
            scl_m = 1'b0; wait_q();
        end
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = ~sda_line;
        bsy = busy;
        if (abort) begin
            reset_n = 1'b0;
            #1;
            check("sda_released_on_reset", 32'(sda_out), 32'd1);
            return;
        end
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q(); scl_m = 1'b1;
            wait_q(); d[i] = sda_line;
            wait_q(); scl_m = 1'b0;
        end
        wait_q(); sda_m = nack;
        wait_q(); scl_m = 1'b1;
        wait_q(); wait_q(); scl_m = 1'b0;
        wait_q(); sda_m = 1'b1;
    endtask

    task automatic bus_write(input logic [7:0] pbyte, input bit race);
        logic ack, bsy;
        i2c_start();
        write_byte(8'hD0, 1'b0, 1'b0, ack, bsy);
        check("ack_wr_addr", 32'(ack), 32'd1);
        check("busy_on_match", 32'(bsy), 32'd1);
        write_byte(pbyte, 1'b0, 1'b0, ack, bsy);
        check("ack_ptr", 32'(ack), 32'd1);
        model_ptr = pbyte[6:0];
        foreach (tx_bytes[i]) begin
            exp_wr_q.push_back({model_ptr, tx_bytes[i]});
            if (race)                    model_regs[model_ptr] = 8'h33;
            else if (model_ptr != 7'd117) model_regs[model_ptr] = tx_bytes[i];
            model_ptr = model_ptr + 7'd1;
            write_byte(tx_bytes[i], race, 1'b0, ack, bsy);
            check("ack_data", 32'(ack), 32'd1);
        end
        i2c_stop();
        check("reg_ptr_after_write", 32'(reg_ptr), 32'(model_ptr));
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic bus_read(input bit set_ptr, input logic [7:0] pbyte, input int n);
        logic ack, bsy;
        logic [7:0] d;
        if (set_ptr) begin
            i2c_start();
            write_byte(8'hD0, 1'b0, 1'b0, ack, bsy);
            check("ack_rd_setup", 32'(ack), 32'd1);
            write_byte(pbyte, 1'b0, 1'b0, ack, bsy);
            check("ack_rd_ptr", 32'(ack), 32'd1);
            model_ptr = pbyte[6:0];
        end
        i2c_start();
        write_byte(8'hD1, 1'b0, 1'b0, ack, bsy);
        check("ack_rd_addr", 32'(ack), 32'd1);
        for (int k = 0; k < n; k++) begin
            exp_rd_q.push_back(model_read(model_ptr));
            model_ptr = model_ptr + 7'd1;
            read_byte(k == n - 1, d);
            obs_rd_q.push_back(d);
        end
        check("busy_after_nack", 32'(busy), 32'd0);
        check("sda_free_after_nack", 32'(sda_line), 32'd1);
        i2c_stop();
        check("reg_ptr_after_read", 32'(reg_ptr), 32'(model_ptr));
    endtask

    task automatic bad_addr(input logic [7:0] abyte);
        logic ack, bsy;
        i2c_start();
        write_byte(abyte, 1'b0, 1'b0, ack, bsy);
        check("nack_bad_addr", 32'(ack), 32'd0);
        check("busy_bad_addr", 32'(bsy), 32'd0);
        write_byte(8'h00, 1'b0, 1'b0, ack, bsy);
        check("nack_ignored_byte", 32'(ack), 32'd0);
        i2c_stop();
    endtask

    initial begin
        logic ack, bsy;
        logic [6:0] a;
        int n;
        model_reset();
        repeat (3) @(negedge clk_in);
        check("rst_sda_out", 32'(sda_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(bus_wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(bus_wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus_wr_data), 32'd0);
        check("rst_reg_ptr", 32'(reg_ptr), 32'd0);
        reset_n = 1'b1;
        wait_q();

        tx_bytes = '{8'h05};
        bus_write(8'h1A, 1'b0);
        bus_read(1'b1, 8'h1A, 1);
        bus_read(1'b1, 8'h75, 1);

        host_write(7'd126, 8'hAA);
        host_write(7'd127, 8'hBB);
        bus_read(1'b1, 8'h7E, 3);

        bad_addr(8'hA0);

        tx_bytes = '{8'h00};
        bus_write(8'h75, 1'b0);
        bus_read(1'b1, 8'h75, 1);
        tx_bytes = '{8'h99};
        bus_write(8'h3B, 1'b1);
        bus_read(1'b1, 8'h3B, 1);

        i2c_start();
        write_byte(8'hD0, 1'b0, 1'b1, ack, bsy);
        check("ack_before_reset", 32'(ack), 32'd1);
        repeat (3) @(negedge clk_in);
        check("busy_in_reset", 32'(busy), 32'd0);
        check("reg_ptr_in_reset", 32'(reg_ptr), 32'd0);
        model_reset();
        sda_m = 1'b1;
        scl_m = 1'b1;
        reset_n = 1'b1;
        wait_q();
        bus_read(1'b1, 8'd107, 1);

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 4);
            case ($urandom_range(0, 4))
                0, 1: begin
                    tx_bytes = {};
                    for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
                    bus_write(8'($urandom), 1'b0);
                end
                2: bus_read(1'b1, 8'($urandom), n);
                3: bus_read(1'b0, 8'h00, n);
                default: begin
                    host_write(7'($urandom), 8'($urandom));
                    a = 7'($urandom);
                    if (a == 7'h68) a = 7'h69;
                    bad_addr({a, 1'($urandom)});
                end
            endcase
        end

        repeat (10) @(negedge clk_in);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
